// File: rtl/nn_dense_engine_if.sv
// Bus between the dense engine and the nn port of the shared dual-port RAM.
//   nn_address  10  byte address
//   nn_wd        8  write data
//   nn_we        1  write enable
//   nn_rd        8  read data, valid one cycle after the address (synchronous RAM)
// master: engine side, slave: RAM side.
interface nn_dense_engine_if;
    logic [9:0] nn_address;
    logic [7:0] nn_wd;
    logic       nn_we;
    logic [7:0] nn_rd;

    modport master (output nn_address, output nn_wd, output nn_we, input nn_rd);
    modport slave  (input nn_address, input nn_wd, input nn_we, output nn_rd);
endinterface

// File: rtl/nn_dense_engine.sv
// Single-layer fully-connected inference engine.
// Reads signed Q1.FRAC inputs, weights and biases from RAM, computes
// acc = bias<<FRAC + sum(x*w) per neuron, applies ReLU with saturation to 0..127
// and writes one byte per neuron back to RAM.
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   run_inference  start strobe, accepted only in idle/done
//   ready          registered, 1 = results valid, held until the next accepted start
//   nn             RAM bus (master modport), registered address/data/write-enable
module nn_dense_engine #(
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_OUT    = 2,
    parameter int unsigned FRAC     = 6,
    parameter int unsigned ACC_W    = 24,
    parameter logic [9:0]  IN_BASE  = 10'h100,
    parameter logic [9:0]  W_BASE   = 10'h140,
    parameter logic [9:0]  B_BASE   = 10'h1C0,
    parameter logic [9:0]  OUT_BASE = 10'h1E0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run_inference,
    output logic                ready,
    nn_dense_engine_if.master   nn
);

    localparam int unsigned IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

    typedef enum logic [2:0] {StIdle, StBias, StX, StW, StLast, StWr, StDone} state_e;

    state_e                    state_q, state_d;
    logic [JW-1:0]             j_q, j_d;
    logic [IW-1:0]             i_q, i_d;
    logic [9:0]                wp_q, wp_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic signed [7:0]         x_q, x_d;
    logic                      ready_q, ready_d;
    logic [9:0]                addr_q, addr_d;
    logic [7:0]                wd_q, wd_d;
    logic                      we_q, we_d;

    logic signed [7:0]         rd_s;
    logic signed [15:0]        prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;

    assign rd_s     = signed'(nn.nn_rd);
    assign prod     = x_q * rd_s;
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_W-8){rd_s[7]}}, rd_s} <<< FRAC;

    // ReLU followed by saturation to the positive 8-bit Q range.
    function automatic logic [7:0] act(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] q;
        logic [7:0]       r;
        q = a >> FRAC;
        if (a[ACC_W-1])              r = 8'd0;
        else if (q > ACC_W'(127))    r = 8'd127;
        else                         r = q[7:0];
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            j_q     <= '0;
            i_q     <= '0;
            wp_q    <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            ready_q <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            i_q     <= i_d;
            wp_q    <= wp_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end

    // Next state and datapath. nn_rd always answers the address of the previous state:
    // in X it holds the bias (i==0) or weight i-1, in W it holds x[i], in LAST the final weight.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        i_d     = i_q;
        wp_d    = wp_q;
        acc_d   = acc_q;
        x_d     = x_q;
        ready_d = ready_q;
        case (state_q)
            StIdle, StDone: begin
                if (run_inference) begin
                    state_d = StBias;
                    j_d     = '0;
                    wp_d    = W_BASE;
                    ready_d = 1'b0;
                end
            end
            StBias: begin
                state_d = StX;
                i_d     = '0;
            end
            StX: begin
                if (i_q == '0) acc_d = bias_ext;
                else           acc_d = acc_q + prod_ext;
                state_d = StW;
            end
            StW: begin
                x_d  = rd_s;
                wp_d = wp_q + 10'd1;
                if (i_q == I_LAST) begin
                    state_d = StLast;
                end else begin
                    i_d     = i_q + 1'b1;
                    state_d = StX;
                end
            end
            StLast: begin
                acc_d   = acc_q + prod_ext;
                state_d = StWr;
            end
            StWr: begin
                if (j_q == J_LAST) begin
                    state_d = StDone;
                    ready_d = 1'b1;
                end else begin
                    j_d     = j_q + 1'b1;
                    state_d = StBias;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus outputs decoded from the state being entered, so they are registered
    // and valid for the whole cycle of that state.
    always_comb begin
        addr_d = '0;
        wd_d   = '0;
        we_d   = 1'b0;
        case (state_d)
            StBias: addr_d = B_BASE + 10'(j_d);
            StX:    addr_d = IN_BASE + 10'(i_d);
            StW:    addr_d = wp_d;
            StWr: begin
                addr_d = OUT_BASE + 10'(j_d);
                wd_d   = act(acc_d);
                we_d   = 1'b1;
            end
            default: ;
        endcase
    end

    assign ready         = ready_q;
    assign nn.nn_address = addr_q;
    assign nn.nn_wd      = wd_q;
    assign nn.nn_we      = we_q;

endmodule

// File: tb/tb_nn_dense_engine.sv
module tb_nn_dense_engine;

    logic clk;
    logic reset;
    logic run_inference;
    logic ready;

    int n_cmp;
    int n_err;
    int we_cnt;

    logic [7:0] mem [1024];
    logic       ld_en;
    logic [9:0] ld_addr;
    logic [7:0] ld_data;

    nn_dense_engine_if bus ();

    nn_dense_engine dut (
        .clk           (clk),
        .reset         (reset),
        .run_inference (run_inference),
        .ready         (ready),
        .nn            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model; bench preloads go through the same process.
    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bus.nn_we) mem[bus.nn_address] <= bus.nn_wd;
        bus.nn_rd <= mem[bus.nn_address];
        if (reset && bus.nn_we) we_cnt <= we_cnt + 1;
    end

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    // xs: x[k] in byte k; ws: w[k] in byte k (row-major); bs: bias[k] in byte k.
    task automatic load(input logic [31:0] xs, input logic [63:0] ws, input logic [15:0] bs);
        for (int k = 0; k < 4; k++) poke(10'h100 + 10'(k), xs[8*k +: 8]);
        for (int k = 0; k < 8; k++) poke(10'h140 + 10'(k), ws[8*k +: 8]);
        for (int k = 0; k < 2; k++) poke(10'h1C0 + 10'(k), bs[8*k +: 8]);
        poke(10'h1E0, 8'h55);
        poke(10'h1E1, 8'h55);
    endtask

    // Pulses a start, follows the run, checks address trace, ready timing, results, write count.
    task automatic run_and_check(input string name, input logic [7:0] e0, input logic [7:0] e1,
                                 input int extra_at, input bit trace);
        int rise_n;
        int we0;
        int idx, jj, k, ii;
        logic [9:0] ea;
        logic       ew;
        we0 = we_cnt;
        run_inference = 1'b1;
        @(posedge clk); #1;
        run_inference = 1'b0;
        n_cmp++;
        if (ready !== 1'b0) begin
            n_err++; $display("FAIL %s ready_after_start: got %b want 0", name, ready);
        end
        rise_n = 0;
        for (int n = 1; n <= 40 && rise_n == 0; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
                run_inference = 1'b0;
            end
            if (ready === 1'b1) begin
                rise_n = n;
            end else begin
                if (trace && n <= 22) begin
                    idx = n - 1; jj = idx / 11; k = idx % 11; ew = 1'b0;
                    if (k == 0) ea = 10'h1C0 + 10'(jj);
                    else if (k <= 8) begin
                        ii = (k - 1) / 2;
                        if (k % 2 == 1) ea = 10'h100 + 10'(ii);
                        else            ea = 10'h140 + 10'(4 * jj + ii);
                    end else begin
                        ea = 10'h1E0 + 10'(jj); ew = 1'b1;
                    end
                    if (k != 9) begin
                        n_cmp++;
                        if (bus.nn_address !== ea || bus.nn_we !== ew) begin
                            n_err++;
                            $display("FAIL %s trace cyc%0d: got addr %h we %b want addr %h we %b",
                                     name, n, bus.nn_address, bus.nn_we, ea, ew);
                        end
                    end
                end
                if (n == extra_at) run_inference = 1'b1;
            end
        end
        n_cmp++;
        if (rise_n != 23) begin
            n_err++; $display("FAIL %s ready_edge: got %0d want 23 (0 = timeout)", name, rise_n);
        end
        n_cmp++;
        if (mem[10'h1E0] !== e0) begin
            n_err++; $display("FAIL %s out0: got %h want %h", name, mem[10'h1E0], e0);
        end
        n_cmp++;
        if (mem[10'h1E1] !== e1) begin
            n_err++; $display("FAIL %s out1: got %h want %h", name, mem[10'h1E1], e1);
        end
        n_cmp++;
        if (we_cnt - we0 != 2) begin
            n_err++; $display("FAIL %s we_count: got %0d want 2", name, we_cnt - we0);
        end
        n_cmp++;
        if (bus.nn_we !== 1'b0 || bus.nn_address !== 10'h0) begin
            n_err++; $display("FAIL %s done_bus: got we %b addr %h want 0 000",
                              name, bus.nn_we, bus.nn_address);
        end
    endtask

    task automatic load_scen2;
        load({8'd64, 8'd64, 8'd64, 8'd64},
             {8'hF8, 8'hF8, 8'hF8, 8'hF8, 8'd8, 8'd8, 8'd8, 8'd8},
             {8'd10, 8'd0});
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || bus.nn_we !== 1'b0 || bus.nn_address !== 10'h0 || bus.nn_wd !== 8'h0)
        begin
            n_err++; $display("FAIL reset_hold: got ready %b we %b addr %h wd %h want 0 0 000 00",
                              ready, bus.nn_we, bus.nn_address, bus.nn_wd);
        end
        reset = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (ready !== 1'b0 || bus.nn_we !== 1'b0 || bus.nn_address !== 10'h0) begin
                n_err++; $display("FAIL idle cyc%0d: got ready %b we %b addr %h want 0 0 000",
                                  c, ready, bus.nn_we, bus.nn_address);
            end
        end
    endtask

    task automatic test_basic_trace;
        load_scen2();
        run_and_check("basic", 8'd32, 8'd0, 0, 1'b1);
    endtask

    task automatic test_saturation;
        load({8'h7F, 8'h7F, 8'h7F, 8'h7F},
             {8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h7F, 8'h7F, 8'h7F},
             {8'h80, 8'h00});
        run_and_check("saturate", 8'd127, 8'd0, 0, 1'b0);
    endtask

    task automatic test_back_to_back;
        load_scen2();
        run_and_check("ignored_start", 8'd32, 8'd0, 5, 1'b1);
        poke(10'h1E0, 8'h55);
        poke(10'h1E1, 8'h55);
        run_and_check("restart_done", 8'd32, 8'd0, 0, 1'b1);
    endtask

    task automatic test_reset_mid_run;
        load_scen2();
        run_inference = 1'b1;
        @(posedge clk); #1;
        run_inference = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.nn_we !== 1'b1) begin
            n_err++; $display("FAIL midrun_we_before: got %b want 1", bus.nn_we);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ready !== 1'b0 || bus.nn_we !== 1'b0 || bus.nn_address !== 10'h0) begin
            n_err++; $display("FAIL midrun_reset: got ready %b we %b addr %h want 0 0 000",
                              ready, bus.nn_we, bus.nn_address);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++;
        if (ready !== 1'b0 || mem[10'h1E0] !== 8'h55) begin
            n_err++; $display("FAIL midrun_after: got ready %b out0 %h want 0 55",
                              ready, mem[10'h1E0]);
        end
        run_and_check("after_reset", 8'd32, 8'd0, 0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        we_cnt = 0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        run_inference = 1'b0;
        reset = 1'b0;
        #1;
        test_reset();
        test_basic_trace();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
